// File: rtl/dvi_frame_reader_pkg.sv
// dvi_frame_reader_pkg: shared states, pixel constants and channel slice positions for the DVI frame reader
package dvi_frame_reader_pkg;
  typedef enum logic [1:0] {
    WAIT_LEVEL = 2'd0,
    WAIT_VS    = 2'd1,
    STREAM     = 2'd2
  } state_e;
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic valid;
  } sync_t;
  localparam logic [23:0] BLACK_PIXEL = 24'h0;
  localparam int R_MSB = 29;
  localparam int G_MSB = 19;
  localparam int B_MSB = 9;
  localparam int SYNC_DELAY = 2;
endpackage

// File: rtl/dvi_frame_reader_sync_delay.sv
// dvi_frame_reader_sync_delay: N-stage shift register carrying timing and the per-slot valid bit
module dvi_frame_reader_sync_delay
  import dvi_frame_reader_pkg::*;
#(
  parameter int N = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  sync_t d_i,
  output sync_t q_o
);
  sync_t pipe_q [N];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < N; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end
  assign q_o = pipe_q[N-1];
endmodule

// File: rtl/dvi_frame_reader.sv
// dvi_frame_reader: pops one FIFO word per active pixel and unpacks 10-bit RGB to RGB888,
// holding black until the FIFO is primed and resynchronising on the next frame after underflow.
module dvi_frame_reader
  import dvi_frame_reader_pkg::*;
#(
  parameter int          DATA_W      = 32,
  parameter int          USEDW_W     = 9,
  parameter int unsigned START_LEVEL = 256,
  parameter logic        VS_ACT      = 1'b0
) (
  input  logic               dvi_clk,
  input  logic               reset,
  input  logic               vpg_de,
  input  logic               vpg_hs,
  input  logic               vpg_vs,
  input  logic [DATA_W-1:0]  fifo_rdata,
  input  logic               fifo_empty,
  input  logic [USEDW_W-1:0] fifo_rdusedw,
  input  logic               clr_status,
  output logic               fifo_rdreq,
  output logic               o_de,
  output logic               o_hs,
  output logic               o_vs,
  output logic [23:0]        o_data,
  output logic               streaming,
  output logic               underflow,
  output logic [15:0]        underflow_cnt,
  output logic [15:0]        frame_cnt
);
  state_e      state_q, state_d;
  logic        vs_q;
  logic [23:0] pix_q;
  logic        uf_q, uf_d;
  logic [15:0] ucnt_q, ucnt_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic        vs_lead, uf_ev, unused_bits;
  sync_t       sync_in, sync_out;
  assign vs_lead    = (vpg_vs == VS_ACT) && (vs_q != VS_ACT);
  assign fifo_rdreq = (state_q == STREAM) && vpg_de && !fifo_empty;
  assign uf_ev      = (state_q == STREAM) && vpg_de && fifo_empty;
  assign unused_bits = ^{fifo_rdata[DATA_W-1:R_MSB+1], fifo_rdata[R_MSB-8:G_MSB+1],
                         fifo_rdata[G_MSB-8:B_MSB+1], fifo_rdata[B_MSB-8:0]};
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_LEVEL: state_d = (fifo_rdusedw >= USEDW_W'(START_LEVEL)) ? WAIT_VS : WAIT_LEVEL;
      WAIT_VS:    state_d = vs_lead ? STREAM : WAIT_VS;
      STREAM:     state_d = uf_ev ? WAIT_LEVEL : STREAM;
      default:    state_d = WAIT_LEVEL;
    endcase
    // a new underflow outranks a simultaneous clear, leaving a fresh count of one
    uf_d   = uf_ev | (uf_q & ~clr_status);
    ucnt_d = uf_ev ? (clr_status ? 16'd1 : (&ucnt_q ? ucnt_q : ucnt_q + 16'd1))
                   : (clr_status ? 16'd0 : ucnt_q);
    fcnt_d = fcnt_q + {15'd0, vs_lead};
  end
  always_ff @(posedge dvi_clk or posedge reset) begin
    if (reset) begin
      state_q <= WAIT_LEVEL;
      vs_q    <= VS_ACT;
      pix_q   <= BLACK_PIXEL;
      uf_q    <= 1'b0;
      ucnt_q  <= 16'd0;
      fcnt_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      vs_q    <= vpg_vs;
      pix_q   <= {fifo_rdata[R_MSB-:8], fifo_rdata[G_MSB-:8], fifo_rdata[B_MSB-:8]};
      uf_q    <= uf_d;
      ucnt_q  <= ucnt_d;
      fcnt_q  <= fcnt_d;
    end
  end
  assign sync_in = {vpg_de, vpg_hs, vpg_vs, fifo_rdreq};
  dvi_frame_reader_sync_delay #(.N(SYNC_DELAY)) u_sync (
    .clk (dvi_clk),
    .rst (reset),
    .d_i (sync_in),
    .q_o (sync_out)
  );
  assign o_de          = sync_out.de;
  assign o_hs          = sync_out.hs;
  assign o_vs          = sync_out.vs;
  assign o_data        = sync_out.valid ? pix_q : BLACK_PIXEL;
  assign streaming     = (state_q == STREAM);
  assign underflow     = uf_q;
  assign underflow_cnt = ucnt_q;
  assign frame_cnt     = fcnt_q;
endmodule

// File: tb/tb_dvi_frame_reader.sv
// tb_dvi_frame_reader: randomized scoreboard bench for dvi_frame_reader with a behavioural FIFO and reader model
module tb_dvi_frame_reader;
  logic        clk = 0, reset = 1;
  logic        vpg_de = 0, vpg_hs = 0, vpg_vs = 1, fifo_empty = 1, clr_status = 0;
  logic [31:0] fifo_rdata = 0;
  logic [8:0]  fifo_rdusedw = 0;
  logic        fifo_rdreq, o_de, o_hs, o_vs, streaming, underflow;
  logic [23:0] o_data;
  logic [15:0] underflow_cnt, frame_cnt;

  dvi_frame_reader dut (
    .dvi_clk(clk), .reset(reset), .vpg_de(vpg_de), .vpg_hs(vpg_hs), .vpg_vs(vpg_vs),
    .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty), .fifo_rdusedw(fifo_rdusedw),
    .clr_status(clr_status), .fifo_rdreq(fifo_rdreq), .o_de(o_de), .o_hs(o_hs), .o_vs(o_vs),
    .o_data(o_data), .streaming(streaming), .underflow(underflow),
    .underflow_cnt(underflow_cnt), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic de, hs, vs;
    logic [23:0] data;
  } exp_t;

  localparam logic [31:0] PAT = 32'h3FF00155;
  exp_t        exp_q[$];
  logic [31:0] fq[$];
  int vectors = 0, miscompares = 0, lvl_ovr = -1, rd_cnt = 0;
  bit emp_ovr = 0, mon_en = 0;
  bit m_play = 0, m_arm = 0, m_flag = 0, m_pvs = 1;
  int m_cnt = 0, m_frames = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [23:0] rgb(input logic [31:0] w);
    int r, g, b;
    r = int'((w >> 20) & 32'h3FF);
    g = int'((w >> 10) & 32'h3FF);
    b = int'(w & 32'h3FF);
    return 24'((r / 4) * 65536 + (g / 4) * 256 + b / 4);
  endfunction

  always @(posedge clk) if (fifo_rdreq && fq.size() > 0) fifo_rdata <= fq.pop_front();

  always @(negedge clk) if (mon_en) begin
    exp_t e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard: no expected entry at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      chk("timing", 32'({o_de, o_hs, o_vs}), 32'({e.de, e.hs, e.vs}));
      chk("pixel", 32'(o_data), 32'(e.data));
    end
  end

  task automatic cyc(input bit de, input bit hs, input bit vs, input bit clr, input bit rp = 0);
    bit lead, rd, und;
    exp_t e;
    @(posedge clk);
    #1;
    if (rp) begin
      reset = 1;
      #1;
      chk("rst_timing", 32'({o_de, o_hs, o_vs}), 32'd0);
      chk("rst_data", 32'(o_data), 32'd0);
      chk("rst_status", 32'({streaming, underflow, fifo_rdreq}), 32'd0);
      chk("rst_ucnt", 32'(underflow_cnt), 32'd0);
      chk("rst_fcnt", 32'(frame_cnt), 32'd0);
      reset = 0;
      m_play = 0; m_arm = 0; m_flag = 0; m_cnt = 0; m_frames = 0;
      exp_q.delete();
      exp_q.push_back('0);
      exp_q.push_back('0);
      mon_en = 1;
    end
    vpg_de = de; vpg_hs = hs; vpg_vs = vs; clr_status = clr;
    fifo_empty = emp_ovr || fq.size() == 0;
    fifo_rdusedw = lvl_ovr >= 0 ? 9'(lvl_ovr) : (fq.size() > 511 ? 9'd511 : 9'(fq.size()));
    lead = !vs && m_pvs;
    rd = m_play && de && !fifo_empty;
    und = m_play && de && fifo_empty;
    e.de = de; e.hs = hs; e.vs = vs;
    e.data = rd ? rgb(fq[0]) : 24'h0;
    exp_q.push_back(e);
    #2;
    chk("rdreq", 32'(fifo_rdreq), 32'(rd));
    chk("streaming", 32'(streaming), 32'(m_play));
    chk("underflow", 32'(underflow), 32'(m_flag));
    chk("underflow_cnt", 32'(underflow_cnt), 32'(m_cnt));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_frames));
    rd_cnt += int'(fifo_rdreq);
    if (m_play) m_play = !und;
    else if (m_arm) begin
      if (lead) begin m_arm = 0; m_play = 1; end
    end else m_arm = int'(fifo_rdusedw) >= 256;
    if (und) begin
      m_flag = 1;
      m_cnt = clr ? 1 : (m_cnt == 65535 ? 65535 : m_cnt + 1);
    end else if (clr) begin
      m_flag = 0;
      m_cnt = 0;
    end
    if (lead) m_frames = (m_frames + 1) % 65536;
    m_pvs = vs;
  endtask

  task automatic line(input int npix, input int hbl, input bit rnd = 0);
    for (int i = 0; i < npix; i++)
      cyc(rnd ? ($urandom % 4 != 0) : 1'b1, 0, 1, rnd && ($urandom % 50 == 0));
    for (int i = 0; i < hbl; i++) cyc(0, i < 2, 1, 0);
  endtask

  task automatic vsync();
    cyc(0, 0, 1, 0); cyc(0, 1, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 1, 0);
  endtask

  task automatic fill(input int n, input bit rnd);
    for (int i = 0; i < n; i++) fq.push_back(rnd ? $urandom : PAT);
  endtask

  task automatic uf_once(input bit clr);
    cyc(0, 0, 1, 0); cyc(0, 0, 0, 0); cyc(1, 0, 1, clr); cyc(0, 0, 1, 0);
  endtask

  initial begin
    int f0;
    cyc(0, 0, 1, 0, 1);
    repeat (3) cyc(0, 0, 1, 0);
    fill(100, 0);
    repeat (2) begin vsync(); line(20, 4); end
    chk("below_level_idle", 32'(streaming), 32'd0);
    fill(540, 0);
    repeat (3) cyc(0, 0, 1, 0);
    vsync();
    chk("stream_entry", 32'(streaming), 32'd1);
    rd_cnt = 0;
    line(640, 8);
    chk("rdreq_count_640", 32'(rd_cnt), 32'd640);
    fill(300, 1);
    rd_cnt = 0;
    line(640, 8);
    chk("uf_rdreq_count", 32'(rd_cnt), 32'd300);
    chk("uf_flag", 32'(underflow), 32'd1);
    chk("uf_cnt", 32'(underflow_cnt), 32'd1);
    chk("uf_state", 32'(streaming), 32'd0);
    line(100, 4);
    fill(300, 1);
    line(50, 4);
    chk("no_rdreq_before_vs", 32'(rd_cnt), 32'd300);
    vsync();
    line(200, 4);
    repeat (8) begin
      fill($urandom_range(0, 300), 1);
      vsync();
      repeat (4) line($urandom_range(10, 60), 4, 1);
      if ($urandom_range(0, 2) == 0) cyc(0, 0, 1, 1);
    end
    lvl_ovr = 256;
    emp_ovr = 1;
    force dut.ucnt_q = 16'hFFFD;
    #1;
    release dut.ucnt_q;
    m_cnt = 'hFFFD;
    repeat (4) uf_once(0);
    chk("ucnt_saturated", 32'(underflow_cnt), 32'h0000FFFF);
    uf_once(1);
    chk("clr_and_uf_cnt", 32'(underflow_cnt), 32'd1);
    chk("clr_and_uf_flag", 32'(underflow), 32'd1);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 0);
    chk("clr_cnt", 32'(underflow_cnt), 32'd0);
    chk("clr_flag", 32'(underflow), 32'd0);
    cyc(0, 0, 1, 0); cyc(0, 0, 0, 0); cyc(0, 0, 1, 0);
    f0 = m_frames;
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("coincident_state", 32'(streaming), 32'd0);
    chk("coincident_fcnt", 32'(frame_cnt), 32'((f0 + 1) % 65536));
    lvl_ovr = -1;
    emp_ovr = 0;
    fq.delete();
    fill(300, 0);
    repeat (2) cyc(0, 0, 1, 0);
    vsync();
    for (int i = 0; i < 100; i++) cyc(1, 0, 1, 0, i == 50);
    chk("post_rst_fcnt", 32'(frame_cnt), 32'd0);
    chk("post_rst_state", 32'(streaming), 32'd0);
    repeat (10) cyc(0, 0, 1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
